am_client_mux: RTL

//  N-to-1 active-message port multiplexer. Merges NUM_CLIENTS client AM channels onto one server channel.
//  TX: per-client ingress FIFOs feed a round-robin arbiter.
//  RX: responses are steered back to per-client FIFOs by head.dstid, so several engines can share one AM server.

---
 rtl/am_pkg.sv | 36 +++
 rtl/am_fifo.sv | 78 +++++++
 rtl/am_client_mux.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/am_pkg.sv
// ---------------------------------------------------------------------------
// am_pkg
//   Shared types and constants for the active-message client multiplexer.
//   Message layout (MSB..LSB): {data, srcid, dstid, arg0, arg1, arg2, arg3}.
//   No ports; imported by am_fifo and am_client_mux.
// ---------------------------------------------------------------------------
package am_pkg;

  localparam int SDARG_BITS = 32;
  localparam int DATA_BITS  = 512;
  localparam int HEAD_BITS  = 6 * SDARG_BITS;
  localparam int MSG_BITS   = DATA_BITS + HEAD_BITS;

  typedef logic [SDARG_BITS-1:0] t_sdarg;
  typedef logic [DATA_BITS-1:0]  t_data;

  typedef struct packed {
    t_sdarg srcid;
    t_sdarg dstid;
    t_sdarg arg0;
    t_sdarg arg1;
    t_sdarg arg2;
    t_sdarg arg3;
  } t_am_head;

  typedef struct packed {
    t_data    data;
    t_am_head head;
  } t_am_full;

  // dstid sits directly above arg0..arg3 in the flattened message.
  function automatic int dstid_lsb(input int sdarg_bits);
    return 4 * sdarg_bits;
  endfunction

endpackage

// File: rtl/am_fifo.sv
// ---------------------------------------------------------------------------
// am_fifo
//   Synchronous first-word-fall-through FIFO. Status flags come from a
//   registered occupancy count. A write while full is dropped and a read
//   while empty is ignored; either raises err_o for that cycle.
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   wr_i, wdata_i       push strobe and data
//   rd_i, rdata_o       pop strobe and head data (valid while !empty_o)
//   full_o, almost_full_o, empty_o, count_o   status
//   err_o               push-while-full or pop-while-empty this cycle
// ---------------------------------------------------------------------------
module am_fifo
  import am_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_SLACK = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       rd_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       almost_full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign full_o        = (cnt_q == CW'(DEPTH));
  assign almost_full_o = (cnt_q >= CW'(DEPTH - AF_SLACK));
  assign empty_o       = (cnt_q == '0);
  assign count_o       = cnt_q;
  assign rdata_o       = mem_q[rptr_q];

  // Full is judged on the registered count, so a same-cycle pop never
  // makes room for a push.
  assign wr_en = wr_i && !full_o;
  assign rd_en = rd_i && !empty_o;
  assign err_o = (wr_i && full_o) || (rd_i && empty_o);

  always_comb begin
    wptr_d = wr_en ? wptr_q + AW'(1) : wptr_q;
    rptr_d = rd_en ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    if (wr_en && !rd_en) cnt_d = cnt_q + CW'(1);
    if (!wr_en && rd_en) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/am_client_mux.sv
// ---------------------------------------------------------------------------
// am_client_mux
//   N-to-1 active-message port multiplexer. Client requests are queued in
//   per-client TX FIFOs and round-robin arbitrated onto one server channel;
//   server responses are steered back to per-client RX FIFOs by head.dstid.
//   Optional build macro AM_CLIENT_MUX_STATS_EN adds per-client 32-bit grant
//   and RX-write counters (stat_tx_cnt / stat_rx_cnt).
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   clt_tx_msg/clt_tx                 client request data and push strobes
//   clt_tx_full/clt_tx_almost_full    client TX FIFO status
//   clt_rx_msg/clt_rx_empty/clt_rx_pop  client RX FIFO head (FWFT)
//   svr_tx_msg/svr_tx/svr_tx_full     server request channel
//   svr_rx_msg/svr_rx_empty/svr_rx_pop  server response channel
//   err_overflow                      sticky per-client overflow/underflow
//   err_bad_dst                       sticky out-of-range response dstid
// ---------------------------------------------------------------------------
module am_client_mux
  import am_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int SDARG_BITS  = am_pkg::SDARG_BITS,
  parameter int DATA_BITS   = am_pkg::DATA_BITS,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4,
  parameter int AF_SLACK    = 1,
  localparam int MSG_BITS   = DATA_BITS + 6 * SDARG_BITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CLIENTS*MSG_BITS-1:0] clt_tx_msg,
  input  logic [NUM_CLIENTS-1:0]          clt_tx,
  output logic [NUM_CLIENTS-1:0]          clt_tx_full,
  output logic [NUM_CLIENTS-1:0]          clt_tx_almost_full,
  output logic [NUM_CLIENTS*MSG_BITS-1:0] clt_rx_msg,
  output logic [NUM_CLIENTS-1:0]          clt_rx_empty,
  input  logic [NUM_CLIENTS-1:0]          clt_rx_pop,
  output logic [MSG_BITS-1:0]             svr_tx_msg,
  output logic                            svr_tx,
  input  logic                            svr_tx_full,
  input  logic [MSG_BITS-1:0]             svr_rx_msg,
  input  logic                            svr_rx_empty,
  output logic                            svr_rx_pop,
  output logic [NUM_CLIENTS-1:0]          err_overflow,
  output logic                            err_bad_dst
`ifdef AM_CLIENT_MUX_STATS_EN
  ,
  output logic [NUM_CLIENTS*32-1:0]       stat_tx_cnt,
  output logic [NUM_CLIENTS*32-1:0]       stat_rx_cnt
`endif
);

  localparam int IDX_W   = $clog2(NUM_CLIENTS);
  localparam int DST_LSB = dstid_lsb(SDARG_BITS);
  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0] tx_empty, tx_pop, tx_err;
  logic [NUM_CLIENTS-1:0] rx_full, rx_wr, rx_err;
  logic [MSG_BITS-1:0]    tx_rdata [NUM_CLIENTS];

  // -------------------------------------------------------------------------
  // Per-client FIFOs
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic                      rx_af;

    am_fifo #(.WIDTH(MSG_BITS), .DEPTH(TX_DEPTH), .AF_SLACK(AF_SLACK)) u_tx (
      .clk_i         (clk),
      .rst_i         (rst),
      .wr_i          (clt_tx[i]),
      .wdata_i       (clt_tx_msg[i*MSG_BITS +: MSG_BITS]),
      .rd_i          (tx_pop[i]),
      .rdata_o       (tx_rdata[i]),
      .full_o        (clt_tx_full[i]),
      .almost_full_o (clt_tx_almost_full[i]),
      .empty_o       (tx_empty[i]),
      .count_o       (tx_count),
      .err_o         (tx_err[i])
    );

    am_fifo #(.WIDTH(MSG_BITS), .DEPTH(RX_DEPTH), .AF_SLACK(AF_SLACK)) u_rx (
      .clk_i         (clk),
      .rst_i         (rst),
      .wr_i          (rx_wr[i]),
      .wdata_i       (svr_rx_msg),
      .rd_i          (clt_rx_pop[i]),
      .rdata_o       (clt_rx_msg[i*MSG_BITS +: MSG_BITS]),
      .full_o        (rx_full[i]),
      .almost_full_o (rx_af),
      .empty_o       (clt_rx_empty[i]),
      .count_o       (rx_count),
      .err_o         (rx_err[i])
    );
  end

  // -------------------------------------------------------------------------
  // Stage 0: round-robin grant over non-empty TX FIFOs
  // -------------------------------------------------------------------------
  logic [2*NUM_CLIENTS-1:0] req_dbl;
  logic [IDX_W-1:0]         rr_q, rr_d, ofs, gnt_idx;
  logic [IDX_W:0]           gnt_sum, rr_nxt;
  logic                     gnt_vld, grant;

  always_comb begin
    // Rotating the doubled request vector right by rr_q puts the search
    // start at bit 0; the lowest set bit is the cyclic winner.
    req_dbl = {~tx_empty, ~tx_empty} >> rr_q;
    gnt_vld = 1'b0;
    ofs     = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (req_dbl[k]) begin
        gnt_vld = 1'b1;
        ofs     = IDX_W'(k);
      end
    end
    gnt_sum = {1'b0, rr_q} + {1'b0, ofs};
    if (gnt_sum >= N_EXT) gnt_sum = gnt_sum - N_EXT;
    gnt_idx = gnt_sum[IDX_W-1:0];
    rr_nxt  = {1'b0, gnt_idx} + (IDX_W+1)'(1);
    if (rr_nxt >= N_EXT) rr_nxt = '0;
    grant   = gnt_vld && !svr_tx_full;
    tx_pop  = '0;
    if (grant) tx_pop[gnt_idx] = 1'b1;
    rr_d    = grant ? rr_nxt[IDX_W-1:0] : rr_q;
  end

  // -------------------------------------------------------------------------
  // RX steering (combinational pop toward the server)
  // -------------------------------------------------------------------------
  logic [SDARG_BITS-1:0] rx_dstid;
  logic [IDX_W-1:0]      rx_dst;
  logic                  rx_bad, rx_ok;

  assign rx_dstid   = svr_rx_msg[DST_LSB +: SDARG_BITS];
  assign rx_bad     = (rx_dstid >= SDARG_BITS'(NUM_CLIENTS));
  assign rx_dst     = rx_dstid[IDX_W-1:0];
  assign rx_ok      = !svr_rx_empty && !rx_bad && !rx_full[rx_dst];
  // A bad destination is always consumed so it cannot wedge the channel;
  // a full destination stalls the whole response stream.
  assign svr_rx_pop = (!svr_rx_empty && rx_bad) || rx_ok;

  always_comb begin
    rx_wr = '0;
    if (rx_ok) rx_wr[rx_dst] = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Stage 1: registered server push and sticky error flags
  // -------------------------------------------------------------------------
  logic                   svr_tx_q, svr_tx_d;
  logic [MSG_BITS-1:0]    svr_tx_msg_q, svr_tx_msg_d;
  logic [NUM_CLIENTS-1:0] err_ovf_q, err_ovf_d;
  logic                   err_bad_q, err_bad_d;

  always_comb begin
    svr_tx_d     = grant;
    svr_tx_msg_d = grant ? tx_rdata[gnt_idx] : svr_tx_msg_q;
    err_ovf_d    = err_ovf_q | tx_err | rx_err;
    err_bad_d    = err_bad_q | (!svr_rx_empty && rx_bad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= '0;
      svr_tx_q     <= 1'b0;
      svr_tx_msg_q <= '0;
      err_ovf_q    <= '0;
      err_bad_q    <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      svr_tx_q     <= svr_tx_d;
      svr_tx_msg_q <= svr_tx_msg_d;
      err_ovf_q    <= err_ovf_d;
      err_bad_q    <= err_bad_d;
    end
  end

  assign svr_tx       = svr_tx_q;
  assign svr_tx_msg   = svr_tx_msg_q;
  assign err_overflow = err_ovf_q;
  assign err_bad_dst  = err_bad_q;

`ifdef AM_CLIENT_MUX_STATS_EN
  logic [NUM_CLIENTS*32-1:0] stat_tx_q, stat_tx_d;
  logic [NUM_CLIENTS*32-1:0] stat_rx_q, stat_rx_d;

  // Free-running counters; 32-bit addition wraps naturally.
  always_comb begin
    stat_tx_d = stat_tx_q;
    stat_rx_d = stat_rx_q;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      stat_tx_d[i*32 +: 32] = stat_tx_q[i*32 +: 32] + 32'(tx_pop[i]);
      stat_rx_d[i*32 +: 32] = stat_rx_q[i*32 +: 32] + 32'(rx_wr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_tx_q <= '0;
      stat_rx_q <= '0;
    end else begin
      stat_tx_q <= stat_tx_d;
      stat_rx_q <= stat_rx_d;
    end
  end

  assign stat_tx_cnt = stat_tx_q;
  assign stat_rx_cnt = stat_rx_q;
`endif

endmodule
